// File: rtl/aes128_decrypt_iter_if.sv
`default_nettype none
// ============================================================================
//  Module  : aes128_decrypt_iter_if
//  Brief   : Key-load, ciphertext-in and plaintext-out handshake bundle for
//            the iterative AES-128 decryption core.
//  Rev     : 1.0  initial release
// ============================================================================
interface aes128_decrypt_iter_if;
    logic [127:0] key;
    logic         key_load;
    logic         key_ready;
    logic [127:0] data_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_out;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output key, key_load, data_in, in_valid, out_ready,
        input  key_ready, in_ready, data_out, out_valid
    );

    modport slave (
        input  key, key_load, data_in, in_valid, out_ready,
        output key_ready, in_ready, data_out, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/aes128_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module  : aes128_decrypt_iter
//  Brief   : Iterative AES-128 decryptor, one round per clock, with an
//            internal 11-entry round-key store expanded once per key.
//  Rev     : 1.0  initial release
// ============================================================================
module aes128_decrypt_iter (
    input  logic                  clk,
    input  logic                  rst,
    aes128_decrypt_iter_if.slave  bus
);

    localparam int          NR         = 10;
    localparam logic [3:0]  LAST_ROUND = 4'd10;
    localparam logic [3:0]  FIRST_DEC  = 4'd9;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_EXPAND = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_DEC    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, polynomial 0x11b
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse; 0 maps to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] v;
        v = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(v);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Inverse round transforms; byte k of a block sits at bits 127-8k
    // ------------------------------------------------------------------
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c-r+4)%4)+r)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(15-4*c)     +: 8];
            a1 = s[8*(15-4*c-1)   +: 8];
            a2 = s[8*(15-4*c-2)   +: 8];
            a3 = s[8*(15-4*c-3)   +: 8];
            o[8*(15-4*c)   +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                 ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[8*(15-4*c-1) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                 ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[8*(15-4*c-2) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                 ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[8*(15-4*c-3) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                 ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]   state_q, state_d;
    logic [127:0] rk_q [0:NR];
    logic [127:0] rk_d [0:NR];
    logic [3:0]   rcnt_q, rcnt_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] data_out_q, data_out_d;
    logic         out_valid_q, out_valid_d;
    logic         key_ready_q, key_ready_d;

    logic [127:0] rk_prev;
    logic [127:0] rk_next;
    logic [127:0] rk_round;
    logic [127:0] round_ark;
    logic [127:0] round_imc;
    logic [31:0]  ks_rot;
    logic [31:0]  ks_temp;
    logic [31:0]  ks_w0, ks_w1, ks_w2, ks_w3;
    logic         in_ready_c;

    // Explicit muxes keep every round-key read inside the 0..10 store
    always_comb begin
        rk_prev  = rk_q[0];
        rk_round = rk_q[0];
        for (int i = 1; i < NR; i++) begin
            if (rcnt_q == 4'(i + 1)) rk_prev  = rk_q[i];
            if (rnd_q  == 4'(i))     rk_round = rk_q[i];
        end
    end

    always_comb begin
        ks_rot  = {rk_prev[23:0], rk_prev[31:24]};
        ks_temp = {sbox(ks_rot[31:24]), sbox(ks_rot[23:16]),
                   sbox(ks_rot[15:8]),  sbox(ks_rot[7:0])}
                ^ {rcon(rcnt_q), 24'h000000};
        ks_w0   = rk_prev[127:96] ^ ks_temp;
        ks_w1   = rk_prev[95:64]  ^ ks_w0;
        ks_w2   = rk_prev[63:32]  ^ ks_w1;
        ks_w3   = rk_prev[31:0]   ^ ks_w2;
        rk_next = {ks_w0, ks_w1, ks_w2, ks_w3};
    end

    always_comb begin
        round_ark = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_round;
        round_imc = inv_mix_columns(round_ark);
    end

    assign in_ready_c = (state_q == S_READY) && !bus.key_load;

    always_comb begin
        state_d     = state_q;
        rk_d        = rk_q;
        rcnt_d      = rcnt_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        key_ready_d = key_ready_q;

        case (state_q)
            S_IDLE: begin
                if (bus.key_load) begin
                    rk_d[0]     = bus.key;
                    rcnt_d      = 4'd1;
                    key_ready_d = 1'b0;
                    state_d     = S_EXPAND;
                end
            end
            S_EXPAND: begin
                for (int i = 1; i <= NR; i++) begin
                    if (rcnt_q == 4'(i)) rk_d[i] = rk_next;
                end
                if (rcnt_q == LAST_ROUND) begin
                    key_ready_d = 1'b1;
                    state_d     = S_READY;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            S_READY: begin
                if (bus.key_load) begin
                    rk_d[0]     = bus.key;
                    rcnt_d      = 4'd1;
                    key_ready_d = 1'b0;
                    state_d     = S_EXPAND;
                end else if (bus.in_valid) begin
                    st_d    = bus.data_in ^ rk_q[NR];
                    rnd_d   = FIRST_DEC;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                if (rnd_q != 4'd0) begin
                    st_d  = round_imc;
                    rnd_d = rnd_q - 4'd1;
                end else begin
                    data_out_d  = round_ark;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_READY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rcnt_q      <= 4'd0;
            rnd_q       <= 4'd0;
            st_q        <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            key_ready_q <= 1'b0;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            key_ready_q <= key_ready_d;
            for (int i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
        end
    end

    assign bus.key_ready = key_ready_q;
    assign bus.in_ready  = in_ready_c;
    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_aes128_decrypt_iter
//  Brief   : Directed FIPS-197 vectors plus random encrypt/decrypt loopback.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_aes128_decrypt_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    aes128_decrypt_iter_if bus();

    aes128_decrypt_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit [7:0] sbox_t [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    function automatic bit [7:0] xt(input bit [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic bit [7:0] rotl8(input bit [7:0] b, input int n);
        bit [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from walking the multiplicative group with generator 3
    task automatic build_sbox();
        bit [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    // Reference AES-128 encryption on byte arrays, column-major state
    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        bit [31:0] w [44];
        bit [31:0] tmp;
        bit [7:0]  s [16];
        bit [7:0]  t [16];
        bit [7:0]  rc;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                    ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) t[4*c+j] = s[4*((c+j)%4)+j];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
                for (int j = 0; j < 4; j++) s[4*c+j] = s[4*c+j] ^ w[4*r+c][31-8*j -: 8];
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // In-valid is held high through the whole expansion to prove it is ignored
    task automatic load_key(input logic [127:0] k, input bit collide, input logic [127:0] blk);
        bus.key      = k;
        bus.key_load = 1'b1;
        if (collide) begin
            bus.in_valid = 1'b1;
            bus.data_in  = blk;
            #1;
            chk("keyload_wins_in_ready", 128'(bus.in_ready), 128'd0);
        end
        step();
        bus.key_load = 1'b0;
        bus.key      = rnd128();
        bus.in_valid = 1'b1;
        bus.data_in  = rnd128();
        chk("expand_key_ready_low", 128'(bus.key_ready), 128'd0);
        chk("expand_in_ready", 128'(bus.in_ready), 128'd0);
        repeat (9) step();
        chk("key_ready_edge9", 128'(bus.key_ready), 128'd0);
        step();
        chk("key_ready_edge10", 128'(bus.key_ready), 128'd1);
        chk("expand_no_output", 128'(bus.out_valid), 128'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic decrypt(input logic [127:0] ct, input logic [127:0] exp,
                           input bit kl_pulse, input int hold);
        int cnt;
        bit stable;
        bus.data_in   = ct;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        chk("ready_in_ready", 128'(bus.in_ready), 128'd1);
        step();
        bus.in_valid = 1'b0;
        bus.data_in  = rnd128();
        chk("dec_in_ready", 128'(bus.in_ready), 128'd0);
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 40) begin
            if (kl_pulse && cnt == 3) begin
                bus.key_load = 1'b1;
                bus.key      = rnd128();
            end
            step();
            bus.key_load = 1'b0;
            cnt++;
        end
        chk("dec_latency", 128'(cnt), 128'd10);
        chk("plaintext", bus.data_out, exp);
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                step();
                if (bus.data_out !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                    stable = 1'b0;
            end
            chk("backpressure_stable", 128'(stable), 128'd1);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("handshake_out_valid", 128'(bus.out_valid), 128'd0);
        chk("handshake_in_ready", 128'(bus.in_ready), 128'd1);
        chk("data_out_kept", bus.data_out, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k, p, c;
        bit quiet;
        build_sbox();
        bus.key       = '0;
        bus.key_load  = 1'b0;
        bus.data_in   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_data_out", bus.data_out, 128'd0);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_key_ready", 128'(bus.key_ready), 128'd0);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.data_in  = C1_CT;
        step();
        chk("idle_in_ready", 128'(bus.in_ready), 128'd0);
        step();
        chk("idle_no_output", 128'(bus.out_valid), 128'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // FIPS-197 C.1, with an ignored key_load during the rounds
        load_key(C1_KEY, 1'b0, '0);
        decrypt(C1_CT, C1_PT, 1'b1, 0);
        decrypt(C1_CT, C1_PT, 1'b0, 0);

        // Re-key with a colliding in_valid, then App. B under backpressure
        load_key(B_KEY, 1'b1, B_CT);
        decrypt(B_CT, B_PT, 1'b0, 20);

        // Reset at round 5 of a decryption
        bus.data_in  = C1_CT;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("midrst_data_out", bus.data_out, 128'd0);
        chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("midrst_key_ready", 128'(bus.key_ready), 128'd0);
        chk("midrst_in_ready", 128'(bus.in_ready), 128'd0);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (12) begin
            step();
            if (bus.out_valid !== 1'b0 || bus.key_ready !== 1'b0 || bus.in_ready !== 1'b0)
                quiet = 1'b0;
        end
        chk("midrst_stays_idle", 128'(quiet), 128'd1);
        load_key(C1_KEY, 1'b0, '0);
        decrypt(C1_CT, C1_PT, 1'b0, 0);

        // Random loopback against the reference encryptor
        for (int n = 0; n < 100; n++) begin
            k = rnd128();
            p = rnd128();
            c = aes_enc(k, p);
            load_key(k, 1'b0, '0);
            decrypt(c, p, 1'b0, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes128_decrypt_iter.md
# aes128_decrypt_iter

Iterative AES-128 decryption core. It is the receive-side counterpart of the outer-round-pipelined AES-128 encryptor and inverts its ciphertext back to plaintext. The core expands the cipher key once into an internal 11-entry round-key store. It then decrypts one block at a time, one round per clock, behind valid/ready handshakes on input and output. It reuses the existing AddRoundKey block and adds InvShiftRows, InvSubBytes and InvMixColumns.

## Interface
- Nk, 4, key length in 32-bit words; only 4 is supported.
- Nr, 10, number of rounds; only 10 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- key  in  128  cipher key (bit 127 = byte 0, FIPS-197 order). Sampled only on a key_load edge.
- key_load  in  1  request key expansion; honoured in IDLE and READY, ignored otherwise.
- key_ready  out  1  round-key store valid.
- data_in  in  128  ciphertext block, same byte order as key.
- in_valid  in  1  data_in valid.
- in_ready  out  1  combinational: (state==READY) && !key_load.
- data_out  out  128  plaintext block.
- out_valid  out  1  data_out valid.
- out_ready  in  1  downstream accepts data_out.

## Operation
- FSM states: IDLE, EXPAND, READY, DEC, DONE. Reset enters IDLE.
- IDLE → EXPAND on key_load.
  - Edge: rk[0]<=key, rcnt<=1, key_ready<=0.
- EXPAND: each edge computes rk[rcnt] from rk[rcnt-1] with the standard schedule (RotWord, SubWord, Rcon[rcnt] = 01,02,04,08,10,20,40,80,1b,36).
  - On the edge with rcnt==10 the state goes to READY and key_ready<=1.
- READY:
  - key_load → EXPAND (re-key); key_ready drops.
  - Otherwise in_valid&&in_ready → DEC. Edge: st<=data_in^rk[10], rnd<=9.
- DEC, rnd 9..1: st <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(st)), rk[rnd])); rnd decrements.
- DEC, rnd==0: data_out <= AddRoundKey(InvSubBytes(InvShiftRows(st)), rk[0]). Same edge: out_valid<=1, state → DONE.
- DONE: data_out and out_valid are held stable until out_valid&&out_ready. On that edge out_valid<=0 and state → READY.
- data_out keeps its last value after the handshake.
- key_load in EXPAND, DEC or DONE is ignored; the round keys stay unchanged during a decryption.
- All AES byte math is GF(2^8) with polynomial 0x11b. There is no key-size or mode configurability.

## Timing
- Reset (synchronous, priority over everything):
  - state=IDLE; key_ready=0, out_valid=0, data_out=0, in_ready=0; rk[*]=0, st=0, counters=0.
- Key expansion: key_load sampled at edge N gives key_ready=1 after edge N+10 (10 busy cycles).
- Decrypt latency: handshake at edge N gives out_valid=1 after edge N+10 (1 whitening edge + 9 full rounds + 1 final round).
  - Throughput is one block per 11 cycles plus the output handshake cycle. There is no overlap between blocks.
- in_ready is 0 in IDLE, EXPAND, DEC and DONE. It is also 0 in READY during any cycle key_load=1, so key_load wins over a simultaneous in_valid.
- out_ready held high in DONE: the handshake completes on the first DONE edge and in_ready is 1 the following cycle.
- out_ready asserted while out_valid=0 has no effect.
- rst mid-EXPAND or mid-DEC aborts the operation: no out_valid, key_ready=0. A new key_load is required.
- Back-to-back re-key: key_load in READY restarts the expansion; the old keys are unusable until the new key_ready.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Expect key_ready 10 edges after load, rk[10]=13111d7fe3944a17f307a78b4d2b30c5.
  - Expect data_out 00112233445566778899aabbccddeeff with out_valid exactly 10 edges after the input handshake.
- FIPS-197 App. B: re-key in READY to 2b7e151628aed2a6abf7158809cf4f3c, then data_in 3925841d02dc09fbdc118597196a0b32.
  - Expect rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Expect data_out 3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready=0 for 20 cycles in DONE.
  - Expect data_out/out_valid stable and in_ready=0.
  - Release: expect one handshake, then in_ready=1 on the next cycle.
- Ignored inputs: pulse in_valid in IDLE/EXPAND and key_load during DEC.
  - Expect no acceptance, no rk change, and the correct plaintext.
- Simultaneous key_load and in_valid in READY: expect in_ready=0, a new expansion, and the block not consumed.
- Reset mid-DEC (round 5): expect all outputs 0 on the next cycle and state IDLE. Key_load plus the C.1 vector then decrypts correctly.
- Loopback: encryptor output fed to this core over 100 random key/plaintext pairs; expect plaintext recovered bit-exact.
